decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second stage of the simplified 5-stage MIPS pipeline. Consumes if_id_instruc and if_id_nextpc from the fetch stage.
- Reads the 32x32 register bank and resolves branches and jumps, driving the fetch redirect controls.
- Detects load-use and branch-operand hazards.
- Registers decoded operands and controls into the execute stage.

Parameters:
- VECTOR_ADDR, 32'd64, exception redirect target (used only with ID_EXCEPTION_EN).
- NREGS, 32, register bank depth. Register 0 reads zero.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ex_if_stall  in  1  execute-stage stall; freezes this stage
- if_id_instruc  in  32  instruction from fetch
- if_id_nextpc  in  32  PC+4 of that instruction
- id_if_selpcsource  out  1  redirect request (combinational)
- id_if_selpctype  out  2  00 branch, 01 register, 10 jump index, 11 vector
- id_if_pcimd2ext  out  32  nextpc + (signext(imm16) << 2)
- id_if_rega  out  32  rs value (jr target)
- id_if_pcindex  out  32  {nextpc[31:28], idx26, 2'b00}
- id_if_stall  out  1  hazard stall; top level ORs it into the fetch stall
- wb_id_writereg  in  1  writeback enable
- wb_id_regdest  in  5  writeback register
- wb_id_writedata  in  32  writeback data
- mem_id_writereg  in  1  MEM stage will write a register
- mem_id_regdest  in  5  MEM destination register
- id_ex_rega, id_ex_regb  out  32  operands
- id_ex_imedext  out  32  extended immediate
- id_ex_aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 lui
- id_ex_alusrc  out  1  1 selects immediate
- id_ex_regdest  out  5  destination register
- id_ex_writereg, id_ex_memread, id_ex_memwrite  out  1  controls
- id_ex_nextpc  out  32  link value for jal

Behaviour:
- Reset: all id_ex_* outputs and every register-bank entry are 0. The same cycle's writeback is ignored.
- Supported subset:
  - R-type: add, sub, and, or, slt, jr.
  - addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal.
- Immediate extension: andi/ori zero-extend; all others sign-extend.
- Register bank: writes on the rising edge when wb_id_writereg=1 and regdest != 0. Reads are combinational with write-through bypass (same-cycle WB to rs/rt returns wb_id_writedata). Register 0 always reads 0.
- Destination register: rd for R-type, rt for I-type, 31 for jal.
  - jal: id_ex_rega=if_id_nextpc, regb=0, aluop=add, alusrc=1, imedext=4, so the ALU writes PC+8.
- Redirect (combinational from current instruction and bank reads):
  - beq taken if rs==rt; bne taken if rs!=rt → selpcsource=1, selpctype=00.
  - jr → 1/01. j, jal → 1/10.
  - Otherwise selpcsource=0 and selpctype=00.
- Delay slot: the instruction already fetched behind a redirect always executes; it is not annulled.
- Hazard stall (id_if_stall=1), evaluated only for valid source registers:
  - Load-use: id_ex_memread=1 and id_ex_regdest matches rs or rt (nonzero).
  - Branch/jr operand: id_ex_writereg=1 or mem_id_writereg=1 with the destination matching a compared/target register.
- Effect of a hazard stall:
  - selpcsource is forced to 0.
  - The next edge loads a bubble (all id_ex controls and regdest = 0).
  - The instruction is re-decoded the next cycle.
- ex_if_stall=1: id_ex_* hold, selpcsource is forced to 0, and id_if_stall is forced to 0. The register bank still accepts writeback.
- Latency: one cycle, decode to id_ex registers.
- Instruction 32'd0 (sll $0) decodes as a bubble.
- Reset has priority over stall.

Optional Feature:
- Macro: ID_EXCEPTION_EN.
- Defined:
  - An unsupported opcode/funct drives selpcsource=1 and selpctype=11 (fetch jumps to VECTOR_ADDR); the instruction itself issues as a bubble.
  - Internal register epc loads if_id_nextpc-4 and is exported as output id_epc[31:0]; reset value 0.
  - Hazard stall masks the exception for that cycle.
- Not defined: unsupported encodings decode as bubbles, selpctype=11 is never produced, and there is no id_epc port.

Decomposition:
- Package mips_pkg:
  - Opcode and funct localparams.
  - aluop encodings, selpctype encodings.
  - VECTOR_ADDR default.
- Sub-module reg_bank: 2 read / 1 write ports, synchronous reset clear, write-through bypass, register 0 hardwired.
- Hazard and redirect logic stay in decode_stage.

Test Plan:
- Reset, then instruction addi $1,$0,5 (0x20010005) → next edge: id_ex_imedext=5, alusrc=1, regdest=1, writereg=1, aluop=000.
- Same-cycle bypass: WB writes $2=0x1234 while decoding beq $2,$2,+3 with nextpc=0x100 → selpcsource=1, selpctype=00, pcimd2ext=0x10C.
- Load-use: lw $3 in EX, decoding add $4,$3,$1 → id_if_stall=1 for one cycle, one bubble into EX, then the add issues with regdest=4.
- jal 0x0000040 at nextpc=0x2004 → selpctype=10, pcindex=0x100, regdest=31. jr $31 holding 0x2008 → selpctype=01, rega=0x2008.
- ex_if_stall held 3 cycles during decode of ori → id_ex_* unchanged and selpcsource=0; WB to $5 still lands and reads back afterwards.
- With ID_EXCEPTION_EN: opcode 0x3F at nextpc=0x40 → selpctype=11, id_epc=0x3C, id_ex_writereg=0. Without the macro: bubble only, selpcsource=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the simplified MIPS pipeline: opcodes, functs, ALU ops,
// fetch redirect types and the decode-stage control bundles.
package mips_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [31:0] VectorAddrDefault = 32'd64;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b100,
        AluLui = 3'b101
    } aluop_e;

    typedef enum logic [1:0] {
        PcBranch = 2'b00,
        PcReg    = 2'b01,
        PcIndex  = 2'b10,
        PcVector = 2'b11
    } pctype_e;

    typedef struct packed {
        logic       valid;
        logic       use_rs;
        logic       use_rt;
        logic       writereg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       zext;
        logic       is_beq;
        logic       is_bne;
        logic       is_jr;
        logic       is_jmp;
        logic       is_jal;
        aluop_e     aluop;
        logic [4:0] regdest;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        aluop_e      aluop;
        logic        alusrc;
        logic [4:0]  regdest;
        logic        writereg;
        logic        memread;
        logic        memwrite;
        logic [31:0] nextpc;
    } idex_t;

endpackage

// File: rtl/reg_bank.sv
// Register bank: two combinational read ports with write-through bypass, one
// write port, synchronous clear; register 0 always reads zero.
module reg_bank #(
    parameter int unsigned NREGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [NREGS];
    logic        wr_en;

    // A writeback presented during reset is dropped, bypass included.
    assign wr_en = we_i && !rst_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != 5'd0) begin
            rdata_a_o = (wr_en && waddr_i == raddr_a_i) ? wdata_i : regs_q[raddr_a_i];
        end
        if (raddr_b_i != 5'd0) begin
            rdata_b_o = (wr_en && waddr_i == raddr_b_i) ? wdata_i : regs_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register read, branch/jump resolution, hazard stall and the
// ID/EX pipeline register. Define ID_EXCEPTION_EN for the unsupported-opcode trap.
module decode_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = VectorAddrDefault,
    parameter int unsigned NREGS       = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_if_stall,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic        id_if_stall,
    input  logic        wb_id_writereg,
    input  logic [4:0]  wb_id_regdest,
    input  logic [31:0] wb_id_writedata,
    input  logic        mem_id_writereg,
    input  logic [4:0]  mem_id_regdest,
`ifdef ID_EXCEPTION_EN
    output logic [31:0] id_epc,
`endif
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_alusrc,
    output logic [4:0]  id_ex_regdest,
    output logic        id_ex_writereg,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic [31:0] id_ex_nextpc
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_ext;
    ctrl_t       ctl;
    idex_t       idex_d, idex_q;
    logic        load_use, br_hz, stall_hz, redir;
    logic        cmp_rs, cmp_rt;
    pctype_e     ptype;

    assign op    = if_id_instruc[31:26];
    assign rs    = if_id_instruc[25:21];
    assign rt    = if_id_instruc[20:16];
    assign rd    = if_id_instruc[15:11];
    assign imm   = if_id_instruc[15:0];
    assign funct = if_id_instruc[5:0];

    // The fetch stage owns the vector mux; keep the parameter referenced here.
    logic unused_vector;
    assign unused_vector = ^VECTOR_ADDR;

    reg_bank #(
        .NREGS(NREGS)
    ) u_reg_bank (
        .clk_i    (clock),
        .rst_i    (reset),
        .we_i     (wb_id_writereg),
        .waddr_i  (wb_id_regdest),
        .wdata_i  (wb_id_writedata),
        .raddr_a_i(rs),
        .raddr_b_i(rt),
        .rdata_a_o(rs_val),
        .rdata_b_o(rt_val)
    );

    always_comb begin
        ctl = '0;
        ctl.aluop = AluAdd;
        case (op)
            OpRtype: begin
                case (funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt: begin
                        ctl.valid    = 1'b1;
                        ctl.use_rs   = 1'b1;
                        ctl.use_rt   = 1'b1;
                        ctl.writereg = 1'b1;
                        ctl.regdest  = rd;
                        ctl.aluop    = (funct == FnSub) ? AluSub :
                                       (funct == FnAnd) ? AluAnd :
                                       (funct == FnOr)  ? AluOr  :
                                       (funct == FnSlt) ? AluSlt : AluAdd;
                    end
                    FnJr: begin
                        ctl.valid  = 1'b1;
                        ctl.use_rs = 1'b1;
                        ctl.is_jr  = 1'b1;
                    end
                    default: ;
                endcase
            end
            OpJ: begin
                ctl.valid  = 1'b1;
                ctl.is_jmp = 1'b1;
            end
            OpJal: begin
                ctl.valid    = 1'b1;
                ctl.is_jmp   = 1'b1;
                ctl.is_jal   = 1'b1;
                ctl.writereg = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.regdest  = 5'd31;
            end
            OpBeq, OpBne: begin
                ctl.valid  = 1'b1;
                ctl.use_rs = 1'b1;
                ctl.use_rt = 1'b1;
                ctl.aluop  = AluSub;
                ctl.is_beq = (op == OpBeq);
                ctl.is_bne = (op == OpBne);
            end
            OpAddi, OpSlti, OpAndi, OpOri, OpLw: begin
                ctl.valid    = 1'b1;
                ctl.use_rs   = 1'b1;
                ctl.writereg = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.regdest  = rt;
                ctl.memread  = (op == OpLw);
                ctl.zext     = (op == OpAndi) || (op == OpOri);
                ctl.aluop    = (op == OpSlti) ? AluSlt :
                               (op == OpAndi) ? AluAnd :
                               (op == OpOri)  ? AluOr  : AluAdd;
            end
            OpLui: begin
                ctl.valid    = 1'b1;
                ctl.writereg = 1'b1;
                ctl.alusrc   = 1'b1;
                ctl.regdest  = rt;
                ctl.aluop    = AluLui;
            end
            OpSw: begin
                ctl.valid    = 1'b1;
                ctl.use_rs   = 1'b1;
                ctl.use_rt   = 1'b1;
                ctl.memwrite = 1'b1;
                ctl.alusrc   = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm_ext = ctl.zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};

    assign id_if_pcimd2ext = if_id_nextpc + {imm_ext[29:0], 2'b00};
    assign id_if_pcindex   = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
    assign id_if_rega      = rs_val;

    // Branches compare rs/rt in this stage, so any in-flight producer of them stalls.
    assign cmp_rs = ctl.is_beq || ctl.is_bne || ctl.is_jr;
    assign cmp_rt = ctl.is_beq || ctl.is_bne;

    assign load_use = idex_q.memread && (idex_q.regdest != 5'd0) &&
                      ((ctl.use_rs && rs == idex_q.regdest) ||
                       (ctl.use_rt && rt == idex_q.regdest));

    assign br_hz = (idex_q.writereg && idex_q.regdest != 5'd0 &&
                    ((cmp_rs && rs == idex_q.regdest) || (cmp_rt && rt == idex_q.regdest))) ||
                   (mem_id_writereg && mem_id_regdest != 5'd0 &&
                    ((cmp_rs && rs == mem_id_regdest) || (cmp_rt && rt == mem_id_regdest)));

    assign stall_hz    = (load_use || br_hz) && !ex_if_stall;
    assign id_if_stall = stall_hz;

`ifdef ID_EXCEPTION_EN
    logic        is_nop, exc;
    logic [31:0] epc_q;
    assign is_nop = (if_id_instruc == 32'd0);
    assign exc    = !ctl.valid && !is_nop;
    assign id_epc = epc_q;
`endif

    always_comb begin
        redir = 1'b0;
        ptype = PcBranch;
        if (ctl.is_jr) begin
            redir = 1'b1;
            ptype = PcReg;
        end else if (ctl.is_jmp) begin
            redir = 1'b1;
            ptype = PcIndex;
        end else if ((ctl.is_beq && rs_val == rt_val) || (ctl.is_bne && rs_val != rt_val)) begin
            redir = 1'b1;
        end
`ifdef ID_EXCEPTION_EN
        if (exc) begin
            redir = 1'b1;
            ptype = PcVector;
        end
`endif
    end

    assign id_if_selpcsource = redir && !stall_hz && !ex_if_stall;
    assign id_if_selpctype   = id_if_selpcsource ? ptype : PcBranch;

    always_comb begin
        idex_d = '0;
        if (ctl.valid && !stall_hz) begin
            idex_d.rega     = ctl.is_jal ? if_id_nextpc : rs_val;
            idex_d.regb     = ctl.is_jal ? 32'd0 : rt_val;
            idex_d.imedext  = ctl.is_jal ? 32'd4 : imm_ext;
            idex_d.aluop    = ctl.aluop;
            idex_d.alusrc   = ctl.alusrc;
            idex_d.regdest  = ctl.regdest;
            idex_d.writereg = ctl.writereg;
            idex_d.memread  = ctl.memread;
            idex_d.memwrite = ctl.memwrite;
            idex_d.nextpc   = if_id_nextpc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q <= '0;
        end else if (!ex_if_stall) begin
            idex_q <= idex_d;
        end
    end

`ifdef ID_EXCEPTION_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            epc_q <= '0;
        end else if (exc && !ex_if_stall && !stall_hz) begin
            epc_q <= if_id_nextpc - 32'd4;
        end
    end
`endif

    assign id_ex_rega     = idex_q.rega;
    assign id_ex_regb     = idex_q.regb;
    assign id_ex_imedext  = idex_q.imedext;
    assign id_ex_aluop    = idex_q.aluop;
    assign id_ex_alusrc   = idex_q.alusrc;
    assign id_ex_regdest  = idex_q.regdest;
    assign id_ex_writereg = idex_q.writereg;
    assign id_ex_memread  = idex_q.memread;
    assign id_ex_memwrite = idex_q.memwrite;
    assign id_ex_nextpc   = idex_q.nextpc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued when an
// instruction is presented and compared one edge later.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset, ex_if_stall;
    logic [31:0] if_id_instruc, if_id_nextpc;
    logic        id_if_selpcsource, id_if_stall;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext, id_if_rega, id_if_pcindex;
    logic        wb_id_writereg, mem_id_writereg;
    logic [4:0]  wb_id_regdest, mem_id_regdest;
    logic [31:0] wb_id_writedata;
    logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc;
    logic [2:0]  id_ex_aluop;
    logic        id_ex_alusrc, id_ex_writereg, id_ex_memread, id_ex_memwrite;
    logic [4:0]  id_ex_regdest;
`ifdef ID_EXCEPTION_EN
    logic [31:0] id_epc;
`endif

    decode_stage u_dut (
        .clock            (clock),
        .reset            (reset),
        .ex_if_stall      (ex_if_stall),
        .if_id_instruc    (if_id_instruc),
        .if_id_nextpc     (if_id_nextpc),
        .id_if_selpcsource(id_if_selpcsource),
        .id_if_selpctype  (id_if_selpctype),
        .id_if_pcimd2ext  (id_if_pcimd2ext),
        .id_if_rega       (id_if_rega),
        .id_if_pcindex    (id_if_pcindex),
        .id_if_stall      (id_if_stall),
        .wb_id_writereg   (wb_id_writereg),
        .wb_id_regdest    (wb_id_regdest),
        .wb_id_writedata  (wb_id_writedata),
        .mem_id_writereg  (mem_id_writereg),
        .mem_id_regdest   (mem_id_regdest),
`ifdef ID_EXCEPTION_EN
        .id_epc           (id_epc),
`endif
        .id_ex_rega       (id_ex_rega),
        .id_ex_regb       (id_ex_regb),
        .id_ex_imedext    (id_ex_imedext),
        .id_ex_aluop      (id_ex_aluop),
        .id_ex_alusrc     (id_ex_alusrc),
        .id_ex_regdest    (id_ex_regdest),
        .id_ex_writereg   (id_ex_writereg),
        .id_ex_memread    (id_ex_memread),
        .id_ex_memwrite   (id_ex_memwrite),
        .id_ex_nextpc     (id_ex_nextpc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        logic [2:0]  aluop;
        logic        alusrc;
        logic [4:0]  regdest;
        logic        writereg;
        logic        memread;
        logic        memwrite;
        logic [31:0] nextpc;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] ra, input logic [31:0] rb,
                                input logic [31:0] im, input logic [2:0] op,
                                input logic src, input logic [4:0] rd, input logic wr,
                                input logic mr, input logic mw, input logic [31:0] npc);
        exp_t e;
        e.rega = ra; e.regb = rb; e.imedext = im; e.aluop = op; e.alusrc = src;
        e.regdest = rd; e.writereg = wr; e.memread = mr; e.memwrite = mw; e.nextpc = npc;
        return e;
    endfunction

    task automatic push(input exp_t e);
        sb_q.push_back(e);
        last_exp = e;
    endtask

    task automatic tick_pop(input string tag);
        exp_t e;
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".rega"},     id_ex_rega,     e.rega);
            check({tag, ".regb"},     id_ex_regb,     e.regb);
            check({tag, ".imedext"},  id_ex_imedext,  e.imedext);
            check({tag, ".aluop"},    {29'd0, id_ex_aluop},   {29'd0, e.aluop});
            check({tag, ".alusrc"},   {31'd0, id_ex_alusrc},  {31'd0, e.alusrc});
            check({tag, ".regdest"},  {27'd0, id_ex_regdest}, {27'd0, e.regdest});
            check({tag, ".writereg"}, {31'd0, id_ex_writereg}, {31'd0, e.writereg});
            check({tag, ".memread"},  {31'd0, id_ex_memread},  {31'd0, e.memread});
            check({tag, ".memwrite"}, {31'd0, id_ex_memwrite}, {31'd0, e.memwrite});
            check({tag, ".nextpc"},   id_ex_nextpc,   e.nextpc);
        end
    endtask

    task automatic dec(input logic [31:0] instr, input logic [31:0] npc);
        if_id_instruc = instr;
        if_id_nextpc  = npc;
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_id_writereg  = en;
        wb_id_regdest   = rd;
        wb_id_writedata = data;
    endtask

    task automatic redirect_is(input string tag, input logic sel, input logic [1:0] typ);
        check({tag, ".selpcsource"}, {31'd0, id_if_selpcsource}, {31'd0, sel});
        check({tag, ".selpctype"},   {30'd0, id_if_selpctype},   {30'd0, typ});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ex_if_stall = 1'b0;
        if_id_instruc = '0; if_id_nextpc = '0;
        mem_id_writereg = 1'b0; mem_id_regdest = '0;
        wb(1'b1, 5'd7, 32'hDEAD_BEEF);  // must be dropped while in reset
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        check("rst.writereg", {31'd0, id_ex_writereg}, 32'd0);
        check("rst.regdest",  {27'd0, id_ex_regdest},  32'd0);
        check("rst.memread",  {31'd0, id_ex_memread},  32'd0);
        check("rst.rega",     id_ex_rega,    32'd0);
        check("rst.imedext",  id_ex_imedext, 32'd0);

        // addi $1,$0,5
        dec(32'h2001_0005, 32'h4);
        redirect_is("addi", 1'b0, 2'b00);
        check("addi.stall", {31'd0, id_if_stall}, 32'd0);
        push(mk(32'd0, 32'd0, 32'd5, 3'b000, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h4));
        tick_pop("addi");

        // nop while WB writes $1=5
        wb(1'b1, 5'd1, 32'd5);
        dec(32'd0, 32'h8);
        push('0);
        tick_pop("nop");

        // beq $2,$2,+3 with same-cycle WB of $2
        wb(1'b1, 5'd2, 32'h1234);
        dec(32'h1042_0003, 32'h100);
        redirect_is("beq_bypass", 1'b1, 2'b00);
        check("beq_bypass.pcimd2ext", id_if_pcimd2ext, 32'h10C);
        push(mk(32'h1234, 32'h1234, 32'd3, 3'b001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h100));
        tick_pop("beq_bypass");
        wb(1'b0, 5'd0, 32'd0);

        // lw $3,0($1) then load-use add $4,$3,$1
        dec(32'h8C23_0000, 32'h108);
        push(mk(32'd5, 32'd0, 32'd0, 3'b000, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h108));
        tick_pop("lw");
        dec(32'h0061_2020, 32'h10C);
        check("lu.stall", {31'd0, id_if_stall}, 32'd1);
        push('0);
        tick_pop("lu_bubble");
        check("lu.stall_clear", {31'd0, id_if_stall}, 32'd0);
        push(mk(32'd0, 32'd5, 32'h2020, 3'b000, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h10C));
        tick_pop("lu_add");

        // jal 0x40
        dec(32'h0C00_0040, 32'h2004);
        redirect_is("jal", 1'b1, 2'b10);
        check("jal.pcindex", id_if_pcindex, 32'h100);
        push(mk(32'h2004, 32'd0, 32'd4, 3'b000, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 32'h2004));
        tick_pop("jal");

        // jr $31: stalls on jal in EX, then on MEM producer, then resolves with bypass
        dec(32'h03E0_0008, 32'h3000);
        check("jr_ex.stall", {31'd0, id_if_stall}, 32'd1);
        redirect_is("jr_ex", 1'b0, 2'b00);
        push('0);
        tick_pop("jr_ex_bubble");
        mem_id_writereg = 1'b1; mem_id_regdest = 5'd31;
        #1;
        check("jr_mem.stall", {31'd0, id_if_stall}, 32'd1);
        push('0);
        tick_pop("jr_mem_bubble");
        mem_id_writereg = 1'b0; mem_id_regdest = 5'd0;
        wb(1'b1, 5'd31, 32'h2008);
        #1;
        check("jr.stall", {31'd0, id_if_stall}, 32'd0);
        redirect_is("jr", 1'b1, 2'b01);
        check("jr.rega", id_if_rega, 32'h2008);
        push(mk(32'h2008, 32'd0, 32'd8, 3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h3000));
        tick_pop("jr");

        // ex_if_stall for 3 cycles on ori $6,$1,0xF0; WB $5 lands meanwhile
        ex_if_stall = 1'b1;
        wb(1'b1, 5'd5, 32'hABCD);
        dec(32'h3426_00F0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            redirect_is("exstall", 1'b0, 2'b00);
            push(last_exp);
            tick_pop("exstall_hold");
            wb(1'b0, 5'd0, 32'd0);
        end
        // taken beq with a pending hazard: both outputs masked by the EX stall
        mem_id_writereg = 1'b1; mem_id_regdest = 5'd1;
        dec(32'h1021_0005, 32'h304);
        redirect_is("exstall_beq", 1'b0, 2'b00);
        check("exstall_beq.stall", {31'd0, id_if_stall}, 32'd0);
        push(last_exp);
        tick_pop("exstall_beq_hold");
        mem_id_writereg = 1'b0; mem_id_regdest = 5'd0;
        ex_if_stall = 1'b0;
        dec(32'h3426_00F0, 32'h300);
        push(mk(32'd5, 32'd0, 32'h00F0, 3'b011, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h300));
        tick_pop("ori");

        // add $8,$7,$5: $7 write during reset must not have landed, $5 must have
        dec(32'h00E5_4020, 32'h304);
        push(mk(32'd0, 32'hABCD, 32'h4020, 3'b000, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h304));
        tick_pop("add_readback");

        // sw $5,4($1)
        dec(32'hAC25_0004, 32'h308);
        push(mk(32'd5, 32'hABCD, 32'd4, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h308));
        tick_pop("sw");

        // bne taken backwards, beq not taken
        dec(32'h1425_FFFF, 32'h400);
        redirect_is("bne", 1'b1, 2'b00);
        check("bne.pcimd2ext", id_if_pcimd2ext, 32'h3FC);
        push(mk(32'd5, 32'hABCD, 32'hFFFF_FFFF, 3'b001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h400));
        tick_pop("bne");
        dec(32'h1025_FFFF, 32'h404);
        redirect_is("beq_nt", 1'b0, 2'b00);
        push(mk(32'd5, 32'hABCD, 32'hFFFF_FFFF, 3'b001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h404));
        tick_pop("beq_nt");

        // unsupported opcode 0x3F
        dec(32'hFC00_0000, 32'h40);
`ifdef ID_EXCEPTION_EN
        redirect_is("illegal", 1'b1, 2'b11);
`else
        redirect_is("illegal", 1'b0, 2'b00);
`endif
        push('0);
        tick_pop("illegal");
`ifdef ID_EXCEPTION_EN
        check("illegal.epc", id_epc, 32'h3C);
`endif

        // lui $9,0x1234
        dec(32'h3C09_1234, 32'h44);
        push(mk(32'd0, 32'd0, 32'h1234, 3'b101, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h44));
        tick_pop("lui");

        // reset wins over ex_if_stall and clears the bank
        ex_if_stall = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_prio.writereg", {31'd0, id_ex_writereg}, 32'd0);
        check("rst_prio.regdest",  {27'd0, id_ex_regdest},  32'd0);
        check("rst_prio.imedext",  id_ex_imedext, 32'd0);
        reset = 1'b0;
        ex_if_stall = 1'b0;
        dec(32'h00A0_3820, 32'h48);
        push(mk(32'd0, 32'd0, 32'h3820, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h48));
        tick_pop("post_rst_read");

        check("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
